// File: rtl/sdram_ref_arbiter.sv
// sdram_ref_arbiter: periodic auto-refresh bookkeeping plus fixed-priority
// grant (refresh > write > read) for the SDRAM command sequencers.
//   Clk, Rst_n          : clock, asynchronous active-low reset
//   init_done           : power-up init finished (only honoured in S_INIT)
//   wr_req, rd_req      : level requests, not latched
//   *_opt_done          : one-cycle completion pulses from each sequencer
//   auto_refre_en/wr_en/rd_en : one-hot grant enables
//   ref_pend            : number of refreshes owed
//   ref_overflow        : sticky, a refresh tick was lost at saturation
module sdram_ref_arbiter #(
    parameter int REF_PERIOD = 1562,
    parameter int PEND_MAX   = 8,
    parameter int PW         = 4
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          init_done,
    input  logic          wr_req,
    input  logic          rd_req,
    input  logic          ref_opt_done,
    input  logic          wr_opt_done,
    input  logic          rd_opt_done,
    output logic          auto_refre_en,
    output logic          wr_en,
    output logic          rd_en,
    output logic [PW-1:0] ref_pend,
    output logic          ref_overflow
);
    localparam int CW = $clog2(REF_PERIOD + 1);
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_AREF, S_WRITE, S_READ} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic          tick, ref_done;
    always_comb begin
        tick     = (state_q != S_INIT) && (cnt_q == CW'(REF_PERIOD - 1));
        ref_done = (state_q == S_AREF) && ref_opt_done;
        cnt_d    = (state_q == S_INIT || tick) ? '0 : cnt_q + CW'(1);
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        // A tick and a completed refresh in the same cycle cancel out.
        if (tick && !ref_done) begin
            pend_d = (pend_q == PW'(PEND_MAX)) ? pend_q : pend_q + PW'(1);
            ovf_d  = ovf_q || (pend_q == PW'(PEND_MAX));
        end else if (ref_done && !tick) begin
            pend_d = (pend_q == '0) ? pend_q : pend_q - PW'(1);
        end
        state_d = state_q;
        case (state_q)
            S_INIT:  state_d = init_done ? S_IDLE : S_INIT;
            S_IDLE:  state_d = (pend_q != '0) ? S_AREF :
                               wr_req         ? S_WRITE :
                               rd_req         ? S_READ : S_IDLE;
            S_AREF:  state_d = ref_opt_done ? S_IDLE : S_AREF;
            S_WRITE: state_d = wr_opt_done  ? S_IDLE : S_WRITE;
            S_READ:  state_d = rd_opt_done  ? S_IDLE : S_READ;
            default: state_d = S_INIT;
        endcase
    end
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end
    // Enables fall in the done cycle so a sequencer never sees a stale grant.
    assign auto_refre_en = (state_q == S_AREF)  && !ref_opt_done;
    assign wr_en         = (state_q == S_WRITE) && !wr_opt_done;
    assign rd_en         = (state_q == S_READ)  && !rd_opt_done;
    assign ref_pend      = pend_q;
    assign ref_overflow  = ovf_q;
endmodule

// File: tb/tb_sdram_ref_arbiter.sv
// tb_sdram_ref_arbiter: directed vectors for refresh/write/read arbitration
module tb_sdram_ref_arbiter;
    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       init_done, wr_req, rd_req, ref_opt_done, wr_opt_done, rd_opt_done;
    logic       auto_refre_en, wr_en, rd_en, ref_overflow;
    logic [3:0] ref_pend;
    int         checks = 0;
    int         errors = 0;

    // input bits: {init_done, wr_req, rd_req, ref_opt_done, wr_opt_done, rd_opt_done}
    // enable bits: {auto_refre_en, wr_en, rd_en}
    typedef struct {
        logic [5:0] in;
        logic [2:0] en;
        int         pend;
    } vec_t;
    vec_t tbl[$];

    sdram_ref_arbiter #(.REF_PERIOD(20), .PEND_MAX(3), .PW(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .init_done(init_done), .wr_req(wr_req), .rd_req(rd_req),
        .ref_opt_done(ref_opt_done), .wr_opt_done(wr_opt_done), .rd_opt_done(rd_opt_done),
        .auto_refre_en(auto_refre_en), .wr_en(wr_en), .rd_en(rd_en),
        .ref_pend(ref_pend), .ref_overflow(ref_overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [2:0] en, input int pend, input logic ovf);
        logic [2:0] act;
        act = {auto_refre_en, wr_en, rd_en};
        checks++;
        if (act !== en) begin
            errors++;
            $display("FAIL %s enables: got %b want %b", name, act, en);
        end
        checks++;
        if (ref_pend !== 4'(pend)) begin
            errors++;
            $display("FAIL %s ref_pend: got %0d want %0d", name, ref_pend, pend);
        end
        checks++;
        if (ref_overflow !== ovf) begin
            errors++;
            $display("FAIL %s ref_overflow: got %b want %b", name, ref_overflow, ovf);
        end
        checks++;
        if ($countones(act) > 1) begin
            errors++;
            $display("FAIL %s exclusion: got %b want at most one high", name, act);
        end
    endtask

    task automatic step(input logic [5:0] in, input logic [2:0] en, input int pend,
                        input logic ovf, input string name);
        @(negedge Clk);
        {init_done, wr_req, rd_req, ref_opt_done, wr_opt_done, rd_opt_done} = in;
        #1;
        chk(name, en, pend, ovf);
    endtask

    initial begin
        Rst_n = 1'b0;
        {init_done, wr_req, rd_req, ref_opt_done, wr_opt_done, rd_opt_done} = '0;
        // cN = Nth cycle after leaving S_INIT; tick lands in c19, c39, ...
        tbl.push_back('{6'b100000, 3'b000, 0});  // S_INIT, init_done seen
        tbl.push_back('{6'b111000, 3'b000, 0});  // c0 idle, both requests
        tbl.push_back('{6'b111000, 3'b010, 0});  // c1 write wins
        tbl.push_back('{6'b111000, 3'b010, 0});  // c2
        tbl.push_back('{6'b101010, 3'b000, 0});  // c3 wr done drops wr_en
        tbl.push_back('{6'b101000, 3'b000, 0});  // c4 arbitration cycle
        tbl.push_back('{6'b101010, 3'b001, 0});  // c5 read, stray wr done
        tbl.push_back('{6'b101100, 3'b001, 0});  // c6 stray ref done ignored
        tbl.push_back('{6'b100001, 3'b000, 0});  // c7 rd done
        tbl.push_back('{6'b100000, 3'b000, 0});  // c8
        tbl.push_back('{6'b110000, 3'b000, 0});  // c9 write request
        tbl.push_back('{6'b110000, 3'b010, 0});  // c10
        tbl.push_back('{6'b101010, 3'b000, 0});  // c11 done, rd pulses
        tbl.push_back('{6'b100000, 3'b000, 0});  // c12 rd dropped, not served
        for (int i = 13; i <= 19; i++) tbl.push_back('{6'b100000, 3'b000, 0});
        tbl.push_back('{6'b110000, 3'b000, 1});  // c20 owed refresh beats write
        tbl.push_back('{6'b110000, 3'b100, 1});  // c21 refresh granted

        repeat (3) @(negedge Clk);
        #1;
        chk("reset", 3'b000, 0, 1'b0);
        Rst_n = 1'b1;
        for (int i = 0; i < 100; i++) step(6'b000000, 3'b000, 0, 1'b0, $sformatf("init_wait%0d", i));

        foreach (tbl[i]) step(tbl[i].in, tbl[i].en, tbl[i].pend, 1'b0, $sformatf("row%0d", i));

        step(6'b100000, 3'b100, 1, 1'b0, "c22");
        step(6'b100100, 3'b000, 1, 1'b0, "c23 ref done");
        step(6'b100000, 3'b000, 0, 1'b0, "c24 pend cleared");
        step(6'b110000, 3'b000, 0, 1'b0, "c25");
        // Long write: ticks at c39/59/79/99 accumulate, saturate, then overflow.
        for (int c = 26; c <= 104; c++)
            step(6'b111000, 3'b010, (c / 20 - 1 > 3) ? 3 : c / 20 - 1, c >= 100, $sformatf("c%0d hold write", c));
        step(6'b101010, 3'b000, 3, 1'b1, "c105 wr done");
        step(6'b101000, 3'b000, 3, 1'b1, "c106");
        step(6'b101000, 3'b100, 3, 1'b1, "c107 ref1");
        step(6'b101100, 3'b000, 3, 1'b1, "c108");
        step(6'b101000, 3'b000, 2, 1'b1, "c109");
        step(6'b101000, 3'b100, 2, 1'b1, "c110 ref2");
        step(6'b101100, 3'b000, 2, 1'b1, "c111");
        step(6'b101000, 3'b000, 1, 1'b1, "c112");
        step(6'b101000, 3'b100, 1, 1'b1, "c113 ref3");
        step(6'b101100, 3'b000, 1, 1'b1, "c114");
        step(6'b101000, 3'b000, 0, 1'b1, "c115");
        step(6'b101000, 3'b001, 0, 1'b1, "c116 read after refreshes");
        step(6'b100001, 3'b000, 0, 1'b1, "c117");
        step(6'b100000, 3'b000, 0, 1'b1, "c118");
        step(6'b100000, 3'b000, 0, 1'b1, "c119 tick");
        step(6'b100000, 3'b000, 1, 1'b1, "c120");
        step(6'b100000, 3'b100, 1, 1'b1, "c121");
        for (int c = 122; c <= 138; c++)
            step((c == 125) ? 6'b100001 : 6'b100000, 3'b100, 1, 1'b1, $sformatf("c%0d aref hold", c));
        step(6'b100100, 3'b000, 1, 1'b1, "c139 done with tick");
        step(6'b100000, 3'b000, 1, 1'b1, "c140 pend unchanged");
        step(6'b100000, 3'b100, 1, 1'b1, "c141");

        @(negedge Clk);
        Rst_n = 1'b0;
        {init_done, wr_req, rd_req, ref_opt_done, wr_opt_done, rd_opt_done} = '0;
        #1;
        chk("reset mid-refresh", 3'b000, 0, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 30; i++) step(6'b011000, 3'b000, 0, 1'b0, $sformatf("reinit%0d", i));
        step(6'b111000, 3'b000, 0, 1'b0, "reinit done");
        step(6'b011000, 3'b000, 0, 1'b0, "reinit idle");
        step(6'b011000, 3'b010, 0, 1'b0, "reinit write");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
